// File: rtl/rtc_day_counter_pkg.sv
// Shared constants and helpers for the real-time-clock day counter.
//   SEC_MAX/MIN_MAX/HR_MAX/DOW_MAX : last legal value of each field
//   HR12_NOON                      : hour at which the 12-hour view flips to PM
//   hr_to_12h                      : maps a 24-hour value to {pm, hr_disp}
package rtc_pkg;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HR_MAX    = 23;
    localparam int unsigned DOW_MAX   = 6;
    localparam int unsigned HR12_NOON = 12;

    typedef struct packed {
        logic       pm;
        logic [4:0] hr_disp;
    } hr12_t;

    function automatic hr12_t hr_to_12h(input logic [4:0] hr);
        hr12_t r;
        if (hr == 5'd0) begin
            r.pm      = 1'b0;
            r.hr_disp = 5'(HR12_NOON);
        end else if (hr < 5'(HR12_NOON)) begin
            r.pm      = 1'b0;
            r.hr_disp = hr;
        end else if (hr == 5'(HR12_NOON)) begin
            r.pm      = 1'b1;
            r.hr_disp = 5'(HR12_NOON);
        end else begin
            r.pm      = 1'b1;
            r.hr_disp = hr - 5'(HR12_NOON);
        end
        return r;
    endfunction

endpackage

// File: rtl/rtc_day_counter_if.sv
// Time-load handshake between a host (master) and the clock (slave).
//   set_valid : load request, sampled on a clk edge
//   set_hr/set_min/set_sec : requested time (24-hour)
//   set_err   : one-cycle pulse from the clock when a request was out of range
interface rtc_day_counter_if;

    logic       set_valid;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;

    modport master (
        output set_valid, set_hr, set_min, set_sec,
        input  set_err
    );

    modport slave (
        input  set_valid, set_hr, set_min, set_sec,
        output set_err
    );

endinterface

// File: rtl/rtc_day_counter_mod_n_counter.sv
// Modulo-N counter with synchronous load, used for each time field.
//   clk, rst  : clock, asynchronous active-low reset (to RESET_VAL)
//   inc       : advance by one this cycle
//   load      : take load_val this cycle (wins over inc)
//   count     : current value 0..N-1
//   wrap      : combinational; high when this cycle's inc takes N-1 back to 0
module mod_n_counter #(
    parameter int unsigned N         = 60,
    parameter int unsigned W         = 6,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        wrap    = inc && !load && (count_q == W'(N - 1));
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= W'(RESET_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rtc_day_counter.sv
// Time-of-day plus day-count timebase: tick prescaler, sec/min/hr cascade,
// day-of-week and free-running elapsed-day counter.
//   clk, rst      : system clock, asynchronous active-low reset
//   en            : run enable; 0 freezes prescaler and counters
//   mode_12h      : selects 12-hour view on hr_disp/pm
//   set_bus       : time-load handshake (slave side)
//   sec/min/hr    : current time, hr always 24-hour
//   hr_disp, pm   : display hour and PM flag (combinational)
//   dow           : day of week 0..6
//   day_count     : elapsed days, wraps silently
//   *_pulse       : one-cycle strobes, high while the new value is visible
module rtc_day_counter
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000000,
    parameter int unsigned DAY_W     = 16,
    parameter int unsigned DOW_RESET = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mode_12h,
    rtc_day_counter_if.slave     set_bus,
    output logic [5:0]           sec,
    output logic [5:0]           min,
    output logic [4:0]           hr,
    output logic [4:0]           hr_disp,
    output logic                 pm,
    output logic [2:0]           dow,
    output logic [DAY_W-1:0]     day_count,
    output logic                 sec_pulse,
    output logic                 min_pulse,
    output logic                 hr_pulse,
    output logic                 day_pulse
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DAY_W-1:0]   day_count_q, day_count_d;
    logic               sec_pulse_q, min_pulse_q, hr_pulse_q, day_pulse_q;
    logic               set_err_q, set_err_d;

    logic  set_ok, load, advance, tick;
    logic  sec_wrap, min_wrap, hr_wrap, dow_wrap_unused;
    hr12_t h12;

    always_comb begin
        set_ok = (set_bus.set_hr  <= 5'(HR_MAX))
              && (set_bus.set_min <= 6'(MIN_MAX))
              && (set_bus.set_sec <= 6'(SEC_MAX));
        load   = set_bus.set_valid && set_ok;
        // Any load request, accepted or rejected, stalls the timebase for the
        // cycle: an accepted one overrides the tick, a rejected one must leave
        // all state untouched.
        advance = en && !set_bus.set_valid;
        tick    = advance && (presc_q == PRESC_W'(TICK_DIV - 1));

        presc_d = presc_q;
        if (load) begin
            presc_d = '0;
        end else if (advance) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        end

        day_count_d = hr_wrap ? day_count_q + DAY_W'(1) : day_count_q;
        set_err_d   = set_bus.set_valid && !set_ok;
    end

    mod_n_counter #(.N(SEC_MAX + 1), .W(6), .RESET_VAL(0)) u_sec (
        .clk(clk), .rst(rst), .inc(tick), .load(load),
        .load_val(set_bus.set_sec), .count(sec), .wrap(sec_wrap)
    );

    mod_n_counter #(.N(MIN_MAX + 1), .W(6), .RESET_VAL(0)) u_min (
        .clk(clk), .rst(rst), .inc(sec_wrap), .load(load),
        .load_val(set_bus.set_min), .count(min), .wrap(min_wrap)
    );

    mod_n_counter #(.N(HR_MAX + 1), .W(5), .RESET_VAL(0)) u_hr (
        .clk(clk), .rst(rst), .inc(min_wrap), .load(load),
        .load_val(set_bus.set_hr), .count(hr), .wrap(hr_wrap)
    );

    mod_n_counter #(.N(DOW_MAX + 1), .W(3), .RESET_VAL(DOW_RESET)) u_dow (
        .clk(clk), .rst(rst), .inc(hr_wrap), .load(1'b0),
        .load_val(3'd0), .count(dow), .wrap(dow_wrap_unused)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            day_count_q <= '0;
            sec_pulse_q <= 1'b0;
            min_pulse_q <= 1'b0;
            hr_pulse_q  <= 1'b0;
            day_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            day_count_q <= day_count_d;
            sec_pulse_q <= tick;
            min_pulse_q <= sec_wrap;
            hr_pulse_q  <= min_wrap;
            day_pulse_q <= hr_wrap;
            set_err_q   <= set_err_d;
        end
    end

    always_comb begin
        h12 = hr_to_12h(hr);
        if (mode_12h) begin
            hr_disp = h12.hr_disp;
            pm      = h12.pm;
        end else begin
            hr_disp = hr;
            pm      = 1'b0;
        end
    end

    assign day_count       = day_count_q;
    assign sec_pulse       = sec_pulse_q;
    assign min_pulse       = min_pulse_q;
    assign hr_pulse        = hr_pulse_q;
    assign day_pulse       = day_pulse_q;
    assign set_bus.set_err = set_err_q;

endmodule
